// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg
//   Shared configuration helpers for the pipelined chunked adder.
//   - PA_DEF_WIDTH / PA_DEF_STAGES : default geometry of pipe_adder
//   - pa_chunk()    : bits resolved per pipeline stage
//   - pa_width_ok() : legality of a WIDTH/STAGES pair (WIDTH must split evenly)
package pipe_adder_pkg;

  localparam int PA_DEF_WIDTH  = 32;
  localparam int PA_DEF_STAGES = 4;

  function automatic int pa_chunk(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit pa_width_ok(input int width, input int stages);
    return (stages > 0) && (width >= stages) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// pipe_adder_stage
//   One registered CHUNK-bit slice of the pipelined ripple adder. Slice IDX adds
//   operand bits [IDX*CHUNK +: CHUNK] with the carry from the previous slice and
//   registers the running partial sum, the chunk carry-out, the operands still to
//   be consumed and an overflow flag for this chunk's MSB.
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   v_in           : upstream beat valid
//   ready_in       : downstream can take this stage's contents this cycle
//   a_in, b_in     : effective operands travelling with the beat
//   sum_in         : partial sum resolved by earlier slices (upper bits zero)
//   c_in           : carry into this chunk
//   v_q            : this stage holds a beat
//   a_q, b_q       : operands forwarded to the next slice
//   sum_q          : partial sum including this chunk
//   c_q            : carry out of this chunk
//   ovf_q          : carry-into-chunk-MSB xor carry-out (meaningful in last slice)
module pipe_adder_stage
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = PA_DEF_WIDTH,
  parameter int STAGES = PA_DEF_STAGES,
  parameter int IDX    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             v_in,
  input  logic             ready_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             c_in,
  output logic             v_q,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] sum_q,
  output logic             c_q,
  output logic             ovf_q
);

  localparam int CHUNK = pa_chunk(WIDTH, STAGES);
  localparam int LO    = IDX * CHUNK;
  localparam int HI    = LO + CHUNK - 1;

  logic             v_d;
  logic [WIDTH-1:0] a_d, b_d, sum_d;
  logic             c_d, ovf_d;
  logic [CHUNK:0]   add;
  logic             load;

  always_comb begin
    add   = {1'b0, a_in[HI:LO]} + {1'b0, b_in[HI:LO]} + {{CHUNK{1'b0}}, c_in};
    // Take a new beat (or a bubble) when empty or when our content moves on;
    // otherwise hold everything so a stalled result stays stable.
    load  = !v_q || ready_in;
    v_d   = v_q;
    a_d   = a_q;
    b_d   = b_q;
    sum_d = sum_q;
    c_d   = c_q;
    ovf_d = ovf_q;
    if (load) begin
      v_d          = v_in;
      a_d          = a_in;
      b_d          = b_in;
      sum_d        = sum_in;
      sum_d[HI:LO] = add[CHUNK-1:0];
      c_d          = add[CHUNK];
      // Carry into the chunk MSB is recovered from the MSB sum bit.
      ovf_d        = add[CHUNK] ^ (a_in[HI] ^ b_in[HI] ^ add[CHUNK-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      c_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      v_q   <= v_d;
      a_q   <= a_d;
      b_q   <= b_d;
      sum_q <= sum_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder
//   WIDTH-bit adder split into STAGES registered CHUNK-bit ripple slices behind a
//   valid/ready stream. One op per cycle, latency STAGES cycles, full backpressure.
//   Results are driven straight from the last slice's registers.
// Optional feature: define PIPE_ADDER_SUB_EN to add the per-beat 'sub' port
//   (sum = a - b - cin; cout = 1 means no borrow).
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand beat handshake
//   a, b, cin           : operands and carry-in
//   sub                 : subtract mode for this beat (PIPE_ADDER_SUB_EN only)
//   out_valid/out_ready : result beat handshake
//   sum, cout, ovf      : result mod 2**WIDTH, carry out, two's-complement overflow
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = PA_DEF_WIDTH,
  parameter int STAGES = PA_DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  if (!pa_width_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  // Index 0 is the input side; index k+1 is the register output of slice k.
  logic [STAGES:0]            v_s;
  logic [STAGES:0]            c_s;
  logic [STAGES:0][WIDTH-1:0] a_s, b_s, sum_s;
  logic [STAGES-1:0]          ovf_st;
  logic [STAGES:0]            rdy;

`ifdef PIPE_ADDER_SUB_EN
  // Subtract folds into the operands once, at entry; the beat then carries it.
  assign b_s[0] = b ^ {WIDTH{sub}};
  assign c_s[0] = cin ^ sub;
`else
  assign b_s[0] = b;
  assign c_s[0] = cin;
`endif
  assign v_s[0]   = in_valid;
  assign a_s[0]   = a;
  assign sum_s[0] = '0;

  // Ready ripples back from the consumer; a stage is free if empty or moving.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !v_s[k+1] || rdy[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_adder_stage #(
      .WIDTH (WIDTH),
      .STAGES(STAGES),
      .IDX   (k)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .v_in    (v_s[k]),
      .ready_in(rdy[k+1]),
      .a_in    (a_s[k]),
      .b_in    (b_s[k]),
      .sum_in  (sum_s[k]),
      .c_in    (c_s[k]),
      .v_q     (v_s[k+1]),
      .a_q     (a_s[k+1]),
      .b_q     (b_s[k+1]),
      .sum_q   (sum_s[k+1]),
      .c_q     (c_s[k+1]),
      .ovf_q   (ovf_st[k])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_s[STAGES];
  assign sum       = sum_s[STAGES];
  assign cout      = c_s[STAGES];
  assign ovf       = ovf_st[STAGES-1];

  // Fully consumed operands and intermediate ovf flags have no load.
  logic unused_tail;
  assign unused_tail = ^{a_s[STAGES], b_s[STAGES], ovf_st};

endmodule
